// File: rtl/rf_tree_walker_if.sv
// Sample/result handshakes plus node-memory and feature-mux buses of one tree walker.
// slave is the walker's side; master is the surrounding datapath (memory, mux, producer, consumer).
interface rf_tree_walker_if #(
  parameter int NODE_ADDR_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [255:0]           in_sample;
  logic                   node_rd_en;
  logic [NODE_ADDR_W-1:0] node_addr;
  logic [31:0]            node_rdata;
  logic [7:0]             mux_sel;
  logic [31:0]            mux_y;
  logic [255:0]           mux_d;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_class;
  logic                   out_err;

  modport master (
    output in_valid, in_sample, node_rdata, mux_y, out_ready,
    input  in_ready, node_rd_en, node_addr, mux_sel, mux_d, out_valid, out_class, out_err
  );

  modport slave (
    input  in_valid, in_sample, node_rdata, mux_y, out_ready,
    output in_ready, node_rd_en, node_addr, mux_sel, mux_d, out_valid, out_class, out_err
  );
endinterface

// File: rtl/rf_tree_walker.sv
// Walks one preorder-stored decision tree per sample: 2 cycles per internal node, result 2D+3 after accept.
// Result holds in DONE until out_ready; RF_DEPTH_GUARD_EN bounds each walk to MAX_DEPTH internal nodes.
module rf_tree_walker #(
  parameter int NODE_ADDR_W = 10,
  parameter int ROOT_ADDR   = 0,
  parameter int MAX_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rst,
  rf_tree_walker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NODE_ADDR_W-1:0] addr, addr_nxt;
  logic [3:0]             sel_q, sel_nxt;
  logic [255:0]           mux_d_q;
  logic [7:0]             class_q;
  logic                   in_ready_q, out_valid_q;

  logic                   is_leaf, go_left, guard_hit;
  logic [3:0]             feat;
  logic [15:0]            thr;
  logic [NODE_ADDR_W-1:0] right;

  assign is_leaf = bus.node_rdata[31];
  assign feat    = bus.node_rdata[30:27];
  assign thr     = bus.node_rdata[26:11];
  assign right   = bus.node_rdata[NODE_ADDR_W-1:0];
  assign go_left = (bus.mux_y[15:0] <= thr);

  logic unused_bits;
  assign unused_bits = ^{bus.mux_y[31:16], bus.node_rdata};

`ifdef RF_DEPTH_GUARD_EN
  localparam int DW = $clog2(MAX_DEPTH + 1);
  logic [DW-1:0] depth;
  logic          err_q;

  assign guard_hit   = (depth == DW'(MAX_DEPTH));
  assign bus.out_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid)
        depth <= '0;
      else if (state == EVAL && !is_leaf && !guard_hit)
        depth <= depth + 1'b1;
      if (state == EVAL && (is_leaf || guard_hit))
        err_q <= !is_leaf;
    end
  end
`else
  localparam int unused_max_depth = MAX_DEPTH;
  assign guard_hit   = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = FETCH;
      FETCH: state_nxt = EVAL;
      EVAL:  state_nxt = (is_leaf || guard_hit) ? DONE : FETCH;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mux_sel must follow the node word within EVAL because mux_y is compared in that same cycle.
  always_comb begin
    bus.node_rd_en = (state == FETCH);
    bus.node_addr  = addr;
    sel_nxt        = sel_q;
    addr_nxt       = addr;
    case (state)
      IDLE: if (bus.in_valid) addr_nxt = NODE_ADDR_W'(ROOT_ADDR);
      EVAL: if (!is_leaf) begin
        sel_nxt = feat;
        if (!guard_hit) addr_nxt = go_left ? addr + 1'b1 : right;
      end
      default: ;
    endcase
    bus.mux_sel = {4'b0000, sel_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= NODE_ADDR_W'(ROOT_ADDR);
      sel_q       <= 4'd0;
      mux_d_q     <= '0;
      class_q     <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      addr        <= addr_nxt;
      sel_q       <= sel_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      if (state == IDLE && bus.in_valid)
        mux_d_q <= bus.in_sample;
      if (state == EVAL) begin
        if (is_leaf)        class_q <= bus.node_rdata[7:0];
        else if (guard_hit) class_q <= 8'hFF;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = class_q;
  assign bus.mux_d     = mux_d_q;
endmodule
